// File: rtl/avalon_ram_agent.sv
// Avalon-MM responder around a word-organised RAM with fixed-latency pipelined reads.
// Define AVALON_AGENT_STALL_EN to insert STALL_CYCLES wait states before each request is accepted.
module avalon_ram_agent #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        write,
    input  logic [31:0] host_to_agent,
    input  logic        read,
    output logic        waitrequest,
    output logic [31:0] agent_to_host,
    output logic        readdatavalid
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem_r [DEPTH_WORDS];
    logic [31:0]   offset_s;
    logic          in_range_s;
    logic [AW-1:0] word_idx_s;
    logic          req_s;
    logic          waitrequest_s;
    logic          accept_s;
    logic          wr_en_s;
    logic          rd_accept_s;
    logic [31:0]   rd_data_s;
    logic          vld_r [READ_LATENCY];
    logic [31:0]   dat_r [READ_LATENCY];

    // Decode relative to BASE_ADDR; wrap on subtraction pushes low addresses out of range
    assign offset_s   = address - BASE_ADDR;
    assign in_range_s = (offset_s < SPAN_BYTES);
    assign word_idx_s = offset_s[AW+1:2];
    assign req_s      = read | write;

`ifdef AVALON_AGENT_STALL_EN
    localparam logic [3:0] STALL_MAX = 4'(STALL_CYCLES);
    logic [3:0] stall_cnt_r;

    // Wait-state counter: counts while a request is held, clears on accept or drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 4'd0;
        end else if (!req_s) begin
            stall_cnt_r <= 4'd0;
        end else if (stall_cnt_r < STALL_MAX) begin
            stall_cnt_r <= stall_cnt_r + 4'd1;
        end else begin
            stall_cnt_r <= 4'd0;
        end
    end

    assign waitrequest_s = req_s & ~rst & (stall_cnt_r < STALL_MAX);
`else
    assign waitrequest_s = 1'b0;
`endif

    assign waitrequest = waitrequest_s;
    assign accept_s    = req_s & ~waitrequest_s & ~rst;
    assign wr_en_s     = accept_s & write & in_range_s;
    // A simultaneous read and write keeps the write and drops the read
    assign rd_accept_s = accept_s & read & ~write;
    assign rd_data_s   = in_range_s ? mem_r[word_idx_s] : 32'h0000_0000;

    // Byte-lane write port; contents deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= host_to_agent[8*i +: 8];
                end
            end
        end
    end

    // Read response pipeline; data is zeroed in empty slots so the output bus idles at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_r[i] <= 1'b0;
                dat_r[i] <= 32'h0000_0000;
            end
        end else begin
            vld_r[0] <= rd_accept_s;
            dat_r[0] <= rd_accept_s ? rd_data_s : 32'h0000_0000;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_r[i] <= vld_r[i-1];
                dat_r[i] <= dat_r[i-1];
            end
        end
    end

    assign readdatavalid = vld_r[READ_LATENCY-1];
    assign agent_to_host = dat_r[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_ram_agent.sv
// Directed scoreboard bench for avalon_ram_agent (DEPTH_WORDS=1024, READ_LATENCY=2).
module tb_avalon_ram_agent;

    localparam int unsigned LAT   = 2;
    localparam int unsigned STALL = 3;
`ifdef AVALON_AGENT_STALL_EN
    localparam logic [31:0] EXP_WAIT = 32'(STALL);
`else
    localparam logic [31:0] EXP_WAIT = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic        write = 1'b0;
    logic [31:0] host_to_agent = 32'h0;
    logic        read = 1'b0;
    logic        waitrequest;
    logic [31:0] agent_to_host;
    logic        readdatavalid;

    logic [31:0] exp_rd = 32'h0;
    logic [31:0] exp_q [$];
    int          acc_q [$];
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;

    avalon_ram_agent #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .READ_LATENCY(LAT),
        .STALL_CYCLES(STALL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .byteenable   (byteenable),
        .write        (write),
        .host_to_agent(host_to_agent),
        .read         (read),
        .waitrequest  (waitrequest),
        .agent_to_host(agent_to_host),
        .readdatavalid(readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on each accepted pure read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && read && !write && !waitrequest) begin
            exp_q.push_back(exp_rd);
            acc_q.push_back(cyc + 1);
        end
    end

    // Response side: pop and compare on valid, otherwise the bus must idle at 0
    always @(negedge clk) begin
        if (readdatavalid === 1'b1) begin
            check("rdv_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("rd_data", agent_to_host, exp_q.pop_front());
                check("rd_latency", 32'(cyc - acc_q.pop_front()), 32'(LAT - 1));
            end
        end else begin
            check("idle_data_zero", agent_to_host, 32'h0);
        end
    end

    task automatic xfer(input logic is_wr, input logic is_rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input logic [31:0] exp);
        int n;
        @(negedge clk);
        address = addr; write = is_wr; read = is_rd;
        host_to_agent = data; byteenable = be; exp_rd = exp;
        #1;
        n = 0;
        while (waitrequest === 1'b1 && n < 32) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_cycles", 32'(n), EXP_WAIT);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        read = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_waitrequest", 32'(waitrequest), 32'd0);
        check("rst_rdv", 32'(readdatavalid), 32'd0);
        check("rst_data", agent_to_host, 32'h0);
        read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check("idle_waitrequest", 32'(waitrequest), 32'd0);

        // Full write then immediate read
        xfer(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0);
        xfer(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);
        idle(3);

        // Partial byte-enable merge
        xfer(1'b1, 1'b0, 32'h20, 32'h1122_3344, 4'hF, 32'h0);
        xfer(1'b1, 1'b0, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0);
        xfer(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD);
        idle(3);

        // Preload and back-to-back reads
        for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, 32'(4*i), 32'(i+1), 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) xfer(1'b0, 1'b1, 32'(4*i), 32'h0, 4'h0, 32'(i+1));
        idle(4);

        // Out of range read and write
        xfer(1'b0, 1'b1, 32'h0000_1000, 32'h0, 4'h0, 32'h0);
        xfer(1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0);
        xfer(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h1);
        idle(3);

        // Read and write together: write lands, read gives no response
        xfer(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 32'h0);
        idle(3);
        xfer(1'b0, 1'b1, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D);
        idle(3);

        // Reset flushes in-flight reads
        xfer(1'b0, 1'b1, 32'h4, 32'h0, 4'h0, 32'h2);
        xfer(1'b0, 1'b1, 32'h8, 32'h0, 4'h0, 32'h3);
        #1;
        rst = 1'b1;
        read = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("flush_rdv", 32'(readdatavalid), 32'd0);
        check("flush_data", agent_to_host, 32'h0);
        check("flush_waitrequest", 32'(waitrequest), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(5);

        // Memory survives reset
        xfer(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF);
        idle(6);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
